// File: rtl/l2_bank_arbiter.sv
// Round-robin arbiter that puts NB_MASTERS TCDM requesters onto one L2 bank.
// After reset, and on each init_i request, the bank is first filled with zeros.
module l2_bank_arbiter #(
  parameter int unsigned NB_MASTERS      = 4,
  parameter int unsigned BANK_ADDR_WIDTH = 13,
  parameter int unsigned DATA_WIDTH      = 36,
  parameter logic [31:0] BASE_ADDR       = 32'h1C00_0000
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             init_i,
  output logic                             init_done_o,
  input  logic [NB_MASTERS-1:0]            req_i,
  input  logic [NB_MASTERS*32-1:0]         add_i,
  input  logic [NB_MASTERS-1:0]            wen_i,
  input  logic [NB_MASTERS*DATA_WIDTH/8-1:0] be_i,
  input  logic [NB_MASTERS*DATA_WIDTH-1:0] wdata_i,
  output logic [NB_MASTERS-1:0]            gnt_o,
  output logic [NB_MASTERS-1:0]            r_valid_o,
  output logic [DATA_WIDTH-1:0]            r_rdata_o,
  output logic                             r_opc_o,
  output logic                             mem_req_o,
  output logic                             mem_wen_o,
  output logic [DATA_WIDTH/8-1:0]          mem_be_o,
  output logic [BANK_ADDR_WIDTH-1:0]       mem_addr_o,
  output logic [DATA_WIDTH-1:0]            mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]            mem_rdata_i
);

  localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
  localparam int unsigned PTR_WIDTH = (NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1;
  localparam logic [BANK_ADDR_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [PTR_WIDTH-1:0]       PTR_LAST = PTR_WIDTH'(NB_MASTERS - 1);

  typedef enum logic {
    CLEAR,
    ARB
  } state_e;

  state_e                     state_reg, state_next;
  logic [BANK_ADDR_WIDTH-1:0] cnt_reg, cnt_next;
  logic [PTR_WIDTH-1:0]       ptr_reg, ptr_next;
  logic                       init_done_reg;
  logic [NB_MASTERS-1:0]      rvalid_reg;

  logic [31:0]                add_arr   [NB_MASTERS];
  logic [BE_WIDTH-1:0]        be_arr    [NB_MASTERS];
  logic [DATA_WIDTH-1:0]      wdata_arr [NB_MASTERS];

  generate
    for (genvar gi = 0; gi < NB_MASTERS; gi++) begin : g_unpack
      assign add_arr[gi]   = add_i[gi*32 +: 32];
      assign be_arr[gi]    = be_i[gi*BE_WIDTH +: BE_WIDTH];
      assign wdata_arr[gi] = wdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Cyclic search starting at ptr_reg; the first requester found wins.
  logic                  found;
  logic [PTR_WIDTH-1:0]  winner;
  logic [NB_MASTERS-1:0] rr_gnt;

  always_comb begin
    int                   idx;
    logic [PTR_WIDTH-1:0] idx_w;
    found  = 1'b0;
    winner = '0;
    rr_gnt = '0;
    idx    = 0;
    idx_w  = '0;
    for (int i = 0; i < int'(NB_MASTERS); i++) begin
      idx = int'(ptr_reg) + i;
      if (idx >= int'(NB_MASTERS)) begin
        idx = idx - int'(NB_MASTERS);
      end
      idx_w = PTR_WIDTH'(idx);
      if (!found && req_i[idx_w]) begin
        found  = 1'b1;
        winner = idx_w;
      end
    end
    if (found) begin
      rr_gnt[winner] = 1'b1;
    end
  end

  logic [31:0] addr_diff;
  logic        unused_addr_bits;

  assign addr_diff        = add_arr[winner] - BASE_ADDR;
  assign unused_addr_bits = ^{addr_diff[31:BANK_ADDR_WIDTH+2], addr_diff[1:0]};

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    ptr_next    = ptr_reg;
    gnt_o       = '0;
    mem_req_o   = 1'b0;
    mem_wen_o   = 1'b1;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state_reg)
      CLEAR: begin
        mem_req_o  = 1'b1;
        mem_wen_o  = 1'b0;
        mem_be_o   = '1;
        mem_addr_o = cnt_reg;
        cnt_next   = cnt_reg + 1'b1;
        if (cnt_reg == CNT_MAX) begin
          state_next = ARB;
        end
      end
      ARB: begin
        gnt_o       = rr_gnt;
        mem_req_o   = |req_i;
        mem_wen_o   = wen_i[winner];
        mem_be_o    = be_arr[winner];
        mem_wdata_o = wdata_arr[winner];
        mem_addr_o  = addr_diff[BANK_ADDR_WIDTH+1:2];
        if (found) begin
          ptr_next = (winner == PTR_LAST) ? '0 : winner + 1'b1;
        end
        if (init_i) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = CLEAR;
        cnt_next   = '0;
      end
    endcase
    // The bank must see no access while reset is held, not only after a clock edge.
    if (rst_i) begin
      gnt_o     = '0;
      mem_req_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg     <= CLEAR;
      cnt_reg       <= '0;
      ptr_reg       <= '0;
      init_done_reg <= 1'b0;
      rvalid_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      ptr_reg       <= ptr_next;
      init_done_reg <= (state_next == ARB);
      rvalid_reg    <= gnt_o;
    end
  end

  assign init_done_o = init_done_reg;
  assign r_valid_o   = rvalid_reg;
  assign r_rdata_o   = mem_rdata_i;
  assign r_opc_o     = 1'b0;

endmodule

// File: doc/l2_bank_arbiter.md
L2_BANK_ARBITER -- requirements
Module: l2_bank_arbiter

Interface
REQ-001 SHALL have parameters: NB_MASTERS, default 4, number of TCDM requesters (>=1); BANK_ADDR_WIDTH, default 13, word-address width of the bank; DATA_WIDTH, default 36, bank word width; BASE_ADDR, default 32'h1C00_0000, byte address of bank word 0.
REQ-002 SHALL have one clock and an asynchronous, active-high reset, named and ordered as follows:
- clk_i  in  1  clock.
- rst_i  in  1  async active-high reset.
- init_i  in  1  request a zero-fill of the bank.
- init_done_o  out  1  bank cleared, arbitration active.
- req_i  in  NB_MASTERS  per-master request.
- add_i  in  NB_MASTERS*32  per-master byte address.
- wen_i  in  NB_MASTERS  per-master direction: 1=read, 0=write.
- be_i  in  NB_MASTERS*DATA_WIDTH/8  per-master byte enables, active high.
- wdata_i  in  NB_MASTERS*DATA_WIDTH  per-master write data.
- gnt_o  out  NB_MASTERS  per-master grant.
- r_valid_o  out  NB_MASTERS  per-master response valid.
- r_rdata_o  out  DATA_WIDTH  response data, shared by all masters.
- r_opc_o  out  1  error flag, tied to 0.
- mem_req_o  out  1  bank chip enable, active high.
- mem_wen_o  out  1  bank direction: 1=read, 0=write.
- mem_be_o  out  DATA_WIDTH/8  bank byte enables, active high.
- mem_addr_o  out  BANK_ADDR_WIDTH  bank word address.
- mem_wdata_o  out  DATA_WIDTH  bank write data.
- mem_rdata_i  in  DATA_WIDTH  bank read data, valid one cycle after access.

Function
REQ-003 SHALL implement a two-state FSM, CLEAR and ARB:
- rst_i enters CLEAR with the clear counter at 0.
- CLEAR goes to ARB in the cycle after the counter reaches 2^BANK_ADDR_WIDTH-1.
- ARB goes to CLEAR in the cycle after init_i is sampled high.
REQ-004 In CLEAR the block SHALL drive, once per cycle for counter values 0..2^BANK_ADDR_WIDTH-1:
- mem_req_o=1, mem_wen_o=0, mem_be_o all ones, mem_wdata_o=0, mem_addr_o=counter.
- gnt_o all 0, regardless of req_i.
REQ-005 init_i SHALL be ignored while in CLEAR; the clear does not restart.
REQ-006 init_done_o SHALL be a registered copy of (state==ARB): 0 during CLEAR, 1 from the first ARB cycle.
REQ-007 In ARB, round-robin grant:
- Winner is the first requesting index found searching cyclically from pointer ptr upward.
- gnt_o is one-hot or zero and combinational from req_i in the same cycle.
REQ-008 On a grant, the round-robin pointer SHALL update to ptr <= (winner+1) mod NB_MASTERS; with no grant, ptr holds.
REQ-009 In ARB, the bank-side outputs SHALL be driven as follows:
- mem_req_o = |req_i.
- mem_wen_o, mem_be_o and mem_wdata_o are taken from the winner.
- mem_addr_o = (add_i[winner] - BASE_ADDR)[BANK_ADDR_WIDTH+1:2], with 32-bit modulo subtraction and no range check.
REQ-010 Exactly one cycle after a grant, r_valid_o[winner] SHALL be 1 and all other bits 0, for both reads and writes; r_rdata_o = mem_rdata_i, driven combinationally.
REQ-011 Throughput SHALL be one access per cycle with back-to-back grants; the response latency is fixed at 1 cycle and there is no response backpressure.
REQ-012 If init_i and req_i are high in the same ARB cycle, the request SHALL be granted and its r_valid_o delivered in the next cycle, which is also the first CLEAR cycle.
REQ-013 r_opc_o SHALL be constant 0; r_rdata_o is undefined when no r_valid_o bit is set.
REQ-014 When NB_MASTERS=1, ptr SHALL remain 0 and grant SHALL equal req_i[0] in ARB.

Reset
REQ-015 While rst_i is high, asynchronously and independent of clk_i, the block SHALL force:
- r_valid_o=0, init_done_o=0, ptr=0, counter=0, state=CLEAR.
- mem_req_o=0 and gnt_o=0.
REQ-016 A reset asserted mid-clear or mid-transaction SHALL drop any pending response; after release, the clear restarts from address 0 on the first clock edge.

Verification
REQ-017 With NB_MASTERS=4 and BANK_ADDR_WIDTH=4, release reset -> mem_req_o=1 for 16 cycles with mem_addr_o=0..15, mem_wdata_o=0 and mem_be_o=0xF; init_done_o=1 on cycle 17; gnt_o=0 throughout even with req_i=4'hF.
REQ-018 In ARB with ptr=0 and req_i=4'hF held -> gnt_o sequence 1,2,4,8,1; r_valid_o follows one cycle later as 1,2,4,8.
REQ-019 Master 2 writes add=BASE_ADDR+0x8 with wdata=0x123 and be=0xF, then reads the same address -> mem_addr_o=2 for both accesses; on the read, r_valid_o=4'b0100 and r_rdata_o=0x123 one cycle after gnt.
REQ-020 init_i and req_i[1] high together in ARB -> gnt_o=4'b0010; next cycle r_valid_o=4'b0010 while CLEAR writes address 0; init_done_o=0 for the next 16 cycles.
REQ-021 With ptr=3 and req_i=4'b1001 -> grant master 3, then master 0, then master 3 (pointer wraps correctly).
REQ-022 rst_i pulsed asynchronously while the clear counter is at 7 -> outputs go to their reset values immediately; after release, mem_addr_o restarts at 0.
